// File: rtl/mux_share_arbiter_pkg.sv
// Shared definitions for the mux_share_arbiter round-robin arbiter.
package mux_share_arbiter_pkg;

    localparam int NREQ = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [NREQ-1:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of mask scanning upward
// from (last+1) mod 4 with wrap-around.
module mux_share_arbiter_rr_pick
    import mux_share_arbiter_pkg::*;
(
    input  logic [NREQ-1:0] mask,
    input  logic [1:0]      last,
    output logic [1:0]      win_idx,
    output logic            win_valid
);

    logic [1:0] idx_s;

    // Scan candidates in priority order; the first hit sticks.
    always_comb begin
        win_idx   = 2'd0;
        win_valid = 1'b0;
        idx_s     = 2'd0;
        for (int i = 0; i < NREQ; i++) begin
            idx_s     = last + 2'd1 + 2'(i);
            win_idx   = (mask[idx_s] && !win_valid) ? idx_s : win_idx;
            win_valid = win_valid | mask[idx_s];
        end
    end

endmodule

// File: rtl/mux_share_arbiter.sv
// Round-robin arbiter sharing one registered 4:1 data mux among four requesters.
// Optional forced rotation after HOLD_MAX grant cycles when ARB_TIMEOUT_EN is defined.
module mux_share_arbiter
    import mux_share_arbiter_pkg::*;
#(
    parameter int DW       = 8,
    parameter int HOLD_MAX = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_in,
    input  logic [NREQ*DW-1:0] data_in,
    output logic [NREQ-1:0]   grant_out,
    output logic [1:0]        sel_out,
    output logic [DW-1:0]     y_out,
    output logic              valid_out
);

    state_t          state_r;
    logic [NREQ-1:0] grant_r;
    logic [1:0]      sel_r;
    logic [1:0]      last_r;
    logic [DW-1:0]   y_r;
    logic            valid_r;

    logic [NREQ-1:0] mask_s;
    logic [1:0]      win_idx_s;
    logic            win_valid_s;
    logic            owner_req_s;
    logic            keep_s;

    // While granted, the current owner is never a candidate for handover.
    always_comb begin
        mask_s      = (state_r == GRANT) ? (req_in & ~grant_r) : req_in;
        owner_req_s = req_in[sel_r];
    end

    mux_share_arbiter_rr_pick u_rr_pick (
        .mask      (mask_s),
        .last      (last_r),
        .win_idx   (win_idx_s),
        .win_valid (win_valid_s)
    );

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
    logic [7:0] hold_r;
    logic       force_s;

    // Rotation is forced only when the hold budget is spent and someone else waits.
    always_comb begin
        force_s = (hold_r == HOLD_LAST) && win_valid_s;
        keep_s  = owner_req_s && !force_s;
    end

    // Consecutive-grant counter; restarts on every new grant and at budget end.
    always_ff @(posedge clock) begin
        if (reset) begin
            hold_r <= 8'd0;
        end else if ((state_r != GRANT) || !keep_s) begin
            hold_r <= 8'd0;
        end else if (hold_r == HOLD_LAST) begin
            hold_r <= 8'd0;
        end else if (hold_r != 8'hFF) begin
            hold_r <= hold_r + 8'd1;
        end else begin
            hold_r <= hold_r;
        end
    end
`else
    logic unused_hold_s;

    // The grant lasts as long as the owner keeps requesting.
    always_comb begin
        keep_s        = owner_req_s;
        unused_hold_s = (HOLD_MAX == 0);
    end
`endif

    // Arbitration FSM with registered grant/select, plus the registered data mux.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
            grant_r <= 4'b0000;
            sel_r   <= 2'b00;
            last_r  <= 2'd3;
            y_r     <= '0;
            valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (win_valid_s) begin
                        state_r <= GRANT;
                        grant_r <= onehot4(win_idx_s);
                        sel_r   <= win_idx_s;
                        last_r  <= win_idx_s;
                    end else begin
                        grant_r <= 4'b0000;
                    end
                end
                GRANT: begin
                    if (keep_s) begin
                        grant_r <= grant_r;
                    end else if (win_valid_s) begin
                        grant_r <= onehot4(win_idx_s);
                        sel_r   <= win_idx_s;
                        last_r  <= win_idx_s;
                    end else begin
                        state_r <= IDLE;
                        grant_r <= 4'b0000;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    grant_r <= 4'b0000;
                end
            endcase

            if (grant_r != 4'b0000) begin
                y_r     <= data_in[sel_r*DW +: DW];
                valid_r <= 1'b1;
            end else begin
                valid_r <= 1'b0;
            end
        end
    end

    assign grant_out = grant_r;
    assign sel_out   = sel_r;
    assign y_out     = y_r;
    assign valid_out = valid_r;

endmodule

// File: doc/mux_share_arbiter.md
Name: mux_share_arbiter

Overview:
Round-robin arbiter that shares one 4:1 selection datapath among four requesters.
- Accepts per-requester request lines and data words.
- Grants exactly one requester at a time and drives the mux select.
- Registers the selected word onto a single shared output.
- Sits between four producer blocks and one downstream consumer that has a single input port.

Parameters:
DW, 8, data width of each requester word
HOLD_MAX, 4, maximum consecutive grant cycles before forced rotation (used only with ARB_TIMEOUT_EN); legal range 1..255

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous reset, active-high
req_in  input  4  request line per requester; bit i = requester i
data_in  input  4*DW  requester words; requester i at data_in[i*DW +: DW]
grant_out  output  4  one-hot grant, registered
sel_out  output  2  index of current grant, registered; drives the shared mux select
y_out  output  DW  registered selected word
valid_out  output  1  y_out holds a word from a granted requester

Behaviour:
- One clock. Reset is synchronous and active-high. Ports are named clock and reset.
- Reset values:
  - state = IDLE, grant_out = 4'b0000, sel_out = 2'b00.
  - y_out = 0, valid_out = 0.
  - last pointer = 2'd3, so requester 0 has first priority after reset.
  - hold counter = 0.
- Round-robin pick: from candidate mask M, choose the first set bit scanning from (last+1) mod 4 upward with wrap-around. Index arithmetic is modulo 4 (2-bit natural wrap).
- States:
  - IDLE: grant_out = 0. If req_in != 0, pick winner W with M = req_in. At the next edge: state = GRANT, grant_out = 1<<W, sel_out = W, last = W, hold = 0. If req_in == 0, stay in IDLE.
  - GRANT: the current owner is C = sel_out.
    - If req_in[C] = 1 and no rotation is forced: keep the grant and increment hold (saturating).
    - If req_in[C] = 0: pick among M = req_in & ~(1<<C). If a winner exists, hand over directly at the next edge with no idle bubble (grant, sel, last updated; hold = 0). Otherwise go to IDLE with grant_out = 0.
- Datapath, registered with one-cycle latency:
  - If grant_out != 0 in cycle t, then y_out(t+1) = word sel_out(t) of data_in(t), and valid_out(t+1) = 1.
  - Otherwise valid_out(t+1) = 0 and y_out holds its previous value.
- Overall latency: req rises in cycle 0 while IDLE → grant_out visible in cycle 1 → valid y_out in cycle 2.
- Simultaneous events:
  - Owner drop and a new request in the same cycle: the new request is a candidate.
  - All four requesting: strict rotation 0,1,2,3,0.
- grant_out is always one-hot or zero, and sel_out is consistent with grant_out whenever grant_out != 0.
- Reset asserted mid-grant: all outputs return to their reset values at that edge. Any in-flight word is dropped.

Optional Feature:
Macro ARB_TIMEOUT_EN.
- Defined: in GRANT, when hold == HOLD_MAX-1 and (req_in & ~(1<<C)) != 0, rotation is forced at the next edge to the round-robin winner among the other requesters, even though req_in[C] = 1. If no other requester is pending, the grant is kept and hold resets to 0.
- Not defined: no hold counter is implemented. The grant is held for as long as the owner's req stays high.

Decomposition:
- Shared package: state encoding (IDLE = 1'b0, GRANT = 1'b1) and the constant NREQ = 4.
- One combinational sub-module, rr_pick. Inputs: mask[3:0] and last[1:0]. Outputs: win_idx[1:0] and win_valid.
- rr_pick is instantiated once. The caller applies the candidate mask.

Test Plan:
1. Reset then single request: req_in = 4'b0100, data word2 = 8'hA5 → grant_out = 4'b0100 and sel_out = 2 at cycle 1; y_out = 8'hA5 with valid_out = 1 at cycle 2.
2. All requesting, each owner drops req one cycle after being granted: req_in = 4'b1111 → grant sequence 0001, 0010, 0100, 1000, 0001 with direct handover and no zero cycles.
3. Owner drops while another is pending: owner 1 holds for 3 cycles, req 3 arrives in cycle 2, req 1 falls in cycle 4 → grant_out = 4'b1000 at the next edge, no IDLE cycle.
4. Timeout (ARB_TIMEOUT_EN, HOLD_MAX = 4): req 0 and req 2 held high continuously → grant 0 for exactly 4 cycles, then grant 2 for 4 cycles, alternating. Without the macro, grant 0 persists.
5. Reset mid-grant: assert reset while grant_out = 4'b0010 → next edge grant_out = 0, sel_out = 0, y_out = 0, valid_out = 0. After release with req_in = 4'b1111, the first grant is 4'b0001.
6. Idle return: sole owner drops req and req_in = 0 → grant_out = 0 next cycle, valid_out = 0 the cycle after, y_out holds its last value.
